// File: rtl/seq_match_fsm_if.sv
// Symbol input / match output bundle for seq_match_fsm.
interface seq_match_fsm_if #(
   parameter int W = 2
);
   logic [W-1:0] x_in;
   logic         clr_in;
   logic         sym_valid;
   logic         z;
   logic         z_level;
   logic [7:0]   match_cnt;
   logic [1:0]   state;

   modport master (
      output x_in, clr_in,
      input  sym_valid, z, z_level, match_cnt, state
   );

   modport slave (
      input  x_in, clr_in,
      output sym_valid, z, z_level, match_cnt, state
   );
endinterface

// File: rtl/seq_match_fsm.sv
// Debounced symbol-sequence matcher: synchronises x_in, accepts stable symbol changes, flags PATTERN.
// Optional macro SEQ_OVERLAP_EN keeps fill after a match so overlapping matches are detected.
//
// state  | meaning
// WAIT   | idle, watching for x_s to differ from the last accepted symbol
// STAB   | candidate symbol seen, counting consecutive stable cycles
// ACCEPT | one cycle: commit candidate to history and evaluate match
module seq_match_fsm #(
   parameter int                    W             = 2,
   parameter int                    DEPTH         = 4,
   parameter logic [DEPTH*W-1:0]    PATTERN       = 8'b01_11_10_00,
   parameter int                    STABLE_CYCLES = 4
) (
   input  logic               sys_clk_in,
   input  logic               sys_rst_in,
   seq_match_fsm_if.slave     bus
);
   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_STAB   = 2'd1;
   localparam logic [1:0] ST_ACCEPT = 2'd2;

   localparam logic [3:0] FILL_MAX  = 4'(DEPTH);
   localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

   logic [W-1:0]       sync1_q, sync2_q;
   logic [W-1:0]       x_s;
   logic [W-1:0]       cand_q, cand_d;
   logic [W-1:0]       last_q, last_d;
   logic [1:0]         state_q, state_d;
   logic [7:0]         stab_cnt_q, stab_cnt_d;
   logic [DEPTH*W-1:0] hist_q, hist_d, hist_shift;
   logic [3:0]         fill_q, fill_d, fill_inc;
   logic [7:0]         match_cnt_q, match_cnt_d;
   logic               z_q, z_d;
   logic               z_level_q, z_level_d;
   logic               sym_valid_q, sym_valid_d;
   logic               match;

   assign x_s = sync2_q;

   // Match is judged on the history/fill as they will be after this accept.
   assign hist_shift = {hist_q[DEPTH*W-W-1:0], cand_q};
   assign fill_inc   = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 4'd1;
   assign match      = (hist_shift == PATTERN) && (fill_inc == FILL_MAX);

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      last_d      = last_q;
      stab_cnt_d  = stab_cnt_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      match_cnt_d = match_cnt_q;
      z_d         = 1'b0;
      sym_valid_d = 1'b0;
      z_level_d   = z_level_q;

      case (state_q)
         ST_WAIT: begin
            if (x_s != last_q) begin
               cand_d     = x_s;
               stab_cnt_d = 8'd0;
               state_d    = ST_STAB;
            end
         end
         ST_STAB: begin
            if (x_s != cand_q) begin
               if (x_s == last_q) begin
                  state_d = ST_WAIT;
               end else begin
                  cand_d     = x_s;
                  stab_cnt_d = 8'd0;
               end
            end else if (stab_cnt_q == STAB_LAST) begin
               state_d = ST_ACCEPT;
            end else begin
               stab_cnt_d = stab_cnt_q + 8'd1;
            end
         end
         ST_ACCEPT: begin
            state_d = ST_WAIT;
            last_d  = cand_q;
            // A simultaneous clear discards the symbol but last_sym still moves on.
            if (!bus.clr_in) begin
               hist_d      = hist_shift;
               sym_valid_d = 1'b1;
               z_d         = match;
               z_level_d   = match;
               if (match) begin
`ifdef SEQ_OVERLAP_EN
                  fill_d = fill_inc;
`else
                  fill_d = 4'd0;
`endif
                  if (match_cnt_q != 8'hFF) begin
                     match_cnt_d = match_cnt_q + 8'd1;
                  end
               end else begin
                  fill_d = fill_inc;
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase

      if (bus.clr_in) begin
         hist_d      = '0;
         fill_d      = 4'd0;
         match_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge sys_clk_in or posedge sys_rst_in) begin
      if (sys_rst_in) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         state_q     <= ST_WAIT;
         cand_q      <= '0;
         last_q      <= '0;
         stab_cnt_q  <= 8'd0;
         hist_q      <= '0;
         fill_q      <= 4'd0;
         match_cnt_q <= 8'd0;
         z_q         <= 1'b0;
         z_level_q   <= 1'b0;
         sym_valid_q <= 1'b0;
      end else begin
         sync1_q     <= bus.x_in;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         cand_q      <= cand_d;
         last_q      <= last_d;
         stab_cnt_q  <= stab_cnt_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         match_cnt_q <= match_cnt_d;
         z_q         <= z_d;
         z_level_q   <= z_level_d;
         sym_valid_q <= sym_valid_d;
      end
   end

   assign bus.sym_valid = sym_valid_q;
   assign bus.z         = z_q;
   assign bus.z_level   = z_level_q;
   assign bus.match_cnt = match_cnt_q;
   assign bus.state     = state_q;
endmodule

// File: doc/seq_match_fsm.md
SEQ_MATCH_FSM -- requirements
Module: seq_match_fsm

Interface
REQ-001 Parameter W, default 2, input symbol width in bits (1..8).
REQ-002 Parameter DEPTH, default 4, pattern length in symbols (2..8).
REQ-003 Parameter PATTERN, default 8'b01_11_10_00, DEPTH*W bits; the first symbol occupies the MSBs and the last symbol the LSBs.
REQ-004 Parameter STABLE_CYCLES, default 4, number of consecutive stable cycles required to accept a symbol (1..255).
REQ-005 sys_clk_in  input  1  sole clock; all flops are rising-edge triggered.
REQ-006 sys_rst_in  input  1  asynchronous, active-high reset.
REQ-007 x_in  input  W  asynchronous input symbol bus (switches or buttons).
REQ-008 clr_in  input  1  synchronous clear of history, fill count and match_cnt.
REQ-009 sym_valid  output  1  one-cycle pulse when a new symbol is accepted.
REQ-010 z  output  1  one-cycle pulse on pattern match.
REQ-011 z_level  output  1  high from a match until the next accepted symbol.
REQ-012 match_cnt  output  8  saturating count of matches.
REQ-013 state  output  2  current FSM state: 0 WAIT, 1 STAB, 2 ACCEPT.

Function
REQ-014 x_in shall pass through a 2-flop synchroniser, producing x_s; all logic below shall use x_s only.
REQ-015 In WAIT, when x_s differs from last_sym, the block shall load cand = x_s, clear stab_cnt and go to STAB; otherwise it stays in WAIT.
REQ-016 In STAB, if x_s differs from cand: go to WAIT when x_s equals last_sym; otherwise reload cand with x_s and clear stab_cnt, staying in STAB.
REQ-017 In STAB, when x_s has equalled cand for STABLE_CYCLES consecutive cycles, the block shall go to ACCEPT.
REQ-018 ACCEPT shall last exactly one cycle and shall:
  - set last_sym = cand;
  - shift cand into the DEPTH-entry history;
  - increment fill, saturating at DEPTH;
  - pulse sym_valid;
  - return to WAIT.
REQ-019 A match shall be declared when the updated history equals PATTERN and the updated fill equals DEPTH.
REQ-020 z shall be registered and high in the cycle after ACCEPT when a match occurs.
REQ-021 match_cnt shall increment on z and hold at 255.
REQ-022 z_level shall set together with z and clear on the next sym_valid that is not itself a match.
REQ-023 Latency: a clean x_in change shall produce z (on match) 2 + STABLE_CYCLES + 2 cycles later.
REQ-024 Only changes in the symbol advance the history; a pattern with equal adjacent symbols shall never match, and this is legal, not an error.
REQ-025 When clr_in and ACCEPT occur in the same cycle, clr_in shall win: history, fill and match_cnt are cleared, the symbol is discarded, and last_sym still updates.
REQ-026 Glitches shorter than STABLE_CYCLES after synchronisation shall leave history, fill and outputs unchanged.

Reset
REQ-027 Reset shall force:
  - state = WAIT;
  - synchroniser, cand, last_sym, history, fill and stab_cnt = 0;
  - z, z_level, sym_valid = 0 and match_cnt = 0.
REQ-028 Reset asserted mid-STAB or mid-ACCEPT shall abort immediately, with no sym_valid or z pulse on release.

Configuration
REQ-029 The macro SEQ_OVERLAP_EN shall select overlap behaviour.
  - Defined: overlapping matches are allowed and fill is unchanged after a match.
  - Undefined: fill is cleared to 0 on a match, so DEPTH fresh symbols are needed before the next match.

Verification
REQ-030 Default parameters; reset; x_in steps 1, 3, 2, 0, each held 10 cycles -> 4 sym_valid pulses, one z pulse 8 cycles after the x_in=0 edge, match_cnt = 1.
REQ-031 x_in=1 glitch lasting 2 cycles, then back to 0 -> no sym_valid, state returns to WAIT, history unchanged.
REQ-032 Pattern 1, 3, 2, 0 followed by 1, 3, 2, 0 -> match_cnt = 2 in both builds.
REQ-033 PATTERN = 01_10_01_10; input 1, 2, 1, 2, 1, 2 -> with SEQ_OVERLAP_EN match_cnt = 2; without it match_cnt = 1.
REQ-034 Reset pulsed while in STAB after three symbols -> all outputs 0; a subsequent full pattern is still required for z.
REQ-035 clr_in asserted in the ACCEPT cycle of the 4th symbol -> no z, fill = 0, match_cnt = 0.
